// File: rtl/and_gate_if.sv
// Operand/result bundle for and_gate_core: the operands and their qualifier, plus the
// combinational and registered results.
interface and_gate_if #(
   parameter int unsigned WIDTH = 1
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             in_valid;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] y_q;
   logic             out_valid;

   modport master (output a, b, in_valid, input y, y_q, out_valid);
   modport slave  (input a, b, in_valid, output y, y_q, out_valid);
endinterface

// File: rtl/and_gate_core.sv
// Bitwise AND with a zero-latency result, a registered valid-qualified copy, reduction
// flags and a saturating all-ones counter. Optional parity output: `define AND_GATE_PARITY_EN.
module and_gate_core #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   and_gate_if.slave        bus,
   input  logic             cnt_clr,
   output logic             y_all,
   output logic             y_any,
   output logic [CNT_W-1:0] cnt
`ifdef AND_GATE_PARITY_EN
   ,
   output logic             y_par
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] y_c;
   logic [WIDTH-1:0] res_d, res_q;
   logic             valid_d, valid_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   // Combinational path: no clock or reset involvement
   assign y_c   = bus.a & bus.b;
   assign bus.y = y_c;
   assign y_all = &y_c;
   assign y_any = |y_c;

   // An unknown y_all makes the increment condition non-true, so X never reaches cnt
   always_comb begin
      res_d   = res_q;
      valid_d = 1'b0;
      cnt_d   = cnt_q;
      if (bus.in_valid) begin
         res_d   = y_c;
         valid_d = 1'b1;
      end
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (bus.in_valid && y_all && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         res_q   <= res_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.y_q       = res_q;
   assign bus.out_valid = valid_q;
   assign cnt           = cnt_q;

`ifdef AND_GATE_PARITY_EN
   logic par_d, par_q;

   // Parity tracks the registered result, so it only moves when y_q is loaded
   always_comb begin
      par_d = par_q;
      if (bus.in_valid) begin
         par_d = ^y_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign y_par = par_q;
`endif

endmodule

// File: tb/tb_and_gate_core.sv
// Directed self-checking bench for and_gate_core across several WIDTH/CNT_W configurations.
module tb_and_gate_core;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   and_gate_if #(.WIDTH(1)) if1 ();
   and_gate_if #(.WIDTH(8)) if8 ();
   and_gate_if #(.WIDTH(4)) if4 ();
   and_gate_if #(.WIDTH(4)) ifs ();

   logic       clr1, clr8, clr4, clrs;
   logic       all1, all8, all4, alls;
   logic       any1, any8, any4, anys;
   logic [7:0] cnt1, cnt8, cnt4;
   logic [1:0] cnts;
`ifdef AND_GATE_PARITY_EN
   logic       par1, par8, par4, pars;
`endif

   and_gate_core #(.WIDTH(1), .CNT_W(8)) dut_w1 (
      .clk(clk), .rst_n(rst_n), .bus(if1), .cnt_clr(clr1),
      .y_all(all1), .y_any(any1), .cnt(cnt1)
`ifdef AND_GATE_PARITY_EN
      , .y_par(par1)
`endif
   );

   and_gate_core #(.WIDTH(8), .CNT_W(8)) dut_w8 (
      .clk(clk), .rst_n(rst_n), .bus(if8), .cnt_clr(clr8),
      .y_all(all8), .y_any(any8), .cnt(cnt8)
`ifdef AND_GATE_PARITY_EN
      , .y_par(par8)
`endif
   );

   and_gate_core #(.WIDTH(4), .CNT_W(8)) dut_w4 (
      .clk(clk), .rst_n(rst_n), .bus(if4), .cnt_clr(clr4),
      .y_all(all4), .y_any(any4), .cnt(cnt4)
`ifdef AND_GATE_PARITY_EN
      , .y_par(par4)
`endif
   );

   and_gate_core #(.WIDTH(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .bus(ifs), .cnt_clr(clrs),
      .y_all(alls), .y_any(anys), .cnt(cnts)
`ifdef AND_GATE_PARITY_EN
      , .y_par(pars)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic test_reset();
      if (if8.y_q !== 8'h00) begin n_fail++; $display("FAIL reset_y_q: got %h expected 00", if8.y_q); end
      n_checks++;
      if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", if8.out_valid); end
      n_checks++;
      if (cnt8 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt8); end
      n_checks++;
      if (cnts !== 2'd0) begin n_fail++; $display("FAIL reset_cnt_sat: got %0d expected 0", cnts); end
      n_checks++;
      // Combinational path is live while reset is held
      if4.a = 4'hC; if4.b = 4'hA; #1;
      if (if4.y !== 4'h8) begin n_fail++; $display("FAIL reset_comb_y: got %h expected 8", if4.y); end
      n_checks++;
      if4.a = 4'h0; if4.b = 4'h0;
`ifdef AND_GATE_PARITY_EN
      if (par8 !== 1'b0) begin n_fail++; $display("FAIL reset_y_par: got %b expected 0", par8); end
      n_checks++;
`endif
   endtask

   task automatic test_truth_table();
      logic [1:0] vec [4];
      logic       exp_y [4];
      vec[0] = 2'b00; vec[1] = 2'b01; vec[2] = 2'b10; vec[3] = 2'b11;
      exp_y[0] = 1'b0; exp_y[1] = 1'b0; exp_y[2] = 1'b0; exp_y[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if1.a = vec[i][1]; if1.b = vec[i][0];
         #10;
         if (if1.y !== exp_y[i]) begin n_fail++; $display("FAIL truth_y[%0d]: got %b expected %b", i, if1.y, exp_y[i]); end
         n_checks++;
         if (any1 !== exp_y[i]) begin n_fail++; $display("FAIL truth_any[%0d]: got %b expected %b", i, any1, exp_y[i]); end
         n_checks++;
         if (all1 !== exp_y[i]) begin n_fail++; $display("FAIL truth_all[%0d]: got %b expected %b", i, all1, exp_y[i]); end
         n_checks++;
      end
      if1.a = 1'b0; if1.b = 1'b0;
   endtask

   task automatic test_basic_capture();
      @(negedge clk);
      if8.a = 8'hF0; if8.b = 8'h3C; if8.in_valid = 1'b1;
      #1;
      if (if8.y !== 8'h30) begin n_fail++; $display("FAIL basic_y: got %h expected 30", if8.y); end
      n_checks++;
      if (any8 !== 1'b1 || all8 !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got any=%b all=%b expected any=1 all=0", any8, all8); end
      n_checks++;
      if (if8.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_valid: got %b expected 0", if8.out_valid); end
      n_checks++;
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
      if (if8.y_q !== 8'h30) begin n_fail++; $display("FAIL basic_y_q: got %h expected 30", if8.y_q); end
      n_checks++;
      if (if8.out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b expected 1", if8.out_valid); end
      n_checks++;
      if (cnt8 !== 8'd0) begin n_fail++; $display("FAIL basic_cnt: got %0d expected 0", cnt8); end
      n_checks++;
   endtask

   task automatic test_hold();
      @(negedge clk);
      if4.a = 4'hF; if4.b = 4'hF; if4.in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      if (cnt4 !== 8'd3) begin n_fail++; $display("FAIL hold_cnt_active: got %0d expected 3", cnt4); end
      n_checks++;
      if4.in_valid = 1'b0;
      @(posedge clk); #1;
      if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_out_valid_drop: got %b expected 0", if4.out_valid); end
      n_checks++;
      if (if4.y_q !== 4'hF) begin n_fail++; $display("FAIL hold_y_q_idle1: got %h expected F", if4.y_q); end
      n_checks++;
      // Idle edge with new operands must not disturb the held result
      if4.a = 4'h1;
      @(posedge clk); #1;
      if (if4.y_q !== 4'hF) begin n_fail++; $display("FAIL hold_y_q_idle2: got %h expected F", if4.y_q); end
      n_checks++;
      if (cnt4 !== 8'd3) begin n_fail++; $display("FAIL hold_cnt_final: got %0d expected 3", cnt4); end
      n_checks++;
      if4.a = 4'h0; if4.b = 4'h0;
   endtask

   task automatic test_saturate();
      logic [1:0] exp_c [6];
      exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3;
      exp_c[3] = 2'd3; exp_c[4] = 2'd3; exp_c[5] = 2'd3;
      @(negedge clk);
      ifs.a = 4'hF; ifs.b = 4'hF; ifs.in_valid = 1'b1; clrs = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (cnts !== exp_c[i]) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, cnts, exp_c[i]); end
         n_checks++;
      end
      clrs = 1'b1;
      @(posedge clk); #1;
      if (cnts !== 2'd0) begin n_fail++; $display("FAIL sat_clear_wins: got %0d expected 0", cnts); end
      n_checks++;
      clrs = 1'b0;
      @(posedge clk); #1;
      if (cnts !== 2'd1) begin n_fail++; $display("FAIL sat_after_clear: got %0d expected 1", cnts); end
      n_checks++;
      // Qualified but not all-ones must not count
      ifs.b = 4'h7;
      @(posedge clk); #1;
      if (cnts !== 2'd1) begin n_fail++; $display("FAIL sat_not_all_ones: got %0d expected 1", cnts); end
      n_checks++;
      ifs.in_valid = 1'b0; ifs.a = 4'h0; ifs.b = 4'h0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] va [3];
      logic [7:0] vb [3];
      logic [7:0] ve [3];
      va[0] = 8'hAA; vb[0] = 8'h55; ve[0] = 8'h00;
      va[1] = 8'hFF; vb[1] = 8'h0F; ve[1] = 8'h0F;
      va[2] = 8'hC3; vb[2] = 8'h81; ve[2] = 8'h81;
      @(negedge clk);
      if8.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if8.a = va[i]; if8.b = vb[i];
         @(posedge clk); #1;
         if (if8.y_q !== ve[i] || if8.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b[%0d]: got y_q=%h valid=%b expected y_q=%h valid=1", i, if8.y_q, if8.out_valid, ve[i]);
         end
         n_checks++;
      end
      if8.in_valid = 1'b0;
      if (cnt8 !== 8'd0) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected 0", cnt8); end
      n_checks++;
   endtask

   task automatic test_midstream_reset();
      @(negedge clk);
      if8.a = 8'hFF; if8.b = 8'hFF; if8.in_valid = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      if (cnt8 !== 8'd2 || if8.y_q !== 8'hFF) begin n_fail++; $display("FAIL mid_pre: got cnt=%0d y_q=%h expected cnt=2 y_q=ff", cnt8, if8.y_q); end
      n_checks++;
      #3;
      rst_n = 1'b0; if8.a = 8'h3C;
      #1;
      if (if8.y_q !== 8'h00 || if8.out_valid !== 1'b0 || cnt8 !== 8'd0) begin
         n_fail++;
         $display("FAIL mid_async: got y_q=%h valid=%b cnt=%0d expected 00 0 0", if8.y_q, if8.out_valid, cnt8);
      end
      n_checks++;
      if (if8.y !== 8'h3C) begin n_fail++; $display("FAIL mid_comb_y: got %h expected 3c", if8.y); end
      n_checks++;
      @(posedge clk); #1;
      if (if8.out_valid !== 1'b0 || cnt8 !== 8'd0) begin n_fail++; $display("FAIL mid_held: got valid=%b cnt=%0d expected 0 0", if8.out_valid, cnt8); end
      n_checks++;
      @(negedge clk);
      rst_n = 1'b1; if8.a = 8'h0F;
      @(posedge clk); #1;
      if (if8.y_q !== 8'h0F || if8.out_valid !== 1'b1 || cnt8 !== 8'd0) begin
         n_fail++;
         $display("FAIL mid_fresh: got y_q=%h valid=%b cnt=%0d expected 0f 1 0", if8.y_q, if8.out_valid, cnt8);
      end
      n_checks++;
      if8.a = 8'hFF;
      @(posedge clk); #1;
      if (cnt8 !== 8'd1) begin n_fail++; $display("FAIL mid_recount: got %0d expected 1", cnt8); end
      n_checks++;
      if8.in_valid = 1'b0;
   endtask

`ifdef AND_GATE_PARITY_EN
   task automatic test_parity();
      @(negedge clk);
      if8.a = 8'h07; if8.b = 8'hFF; if8.in_valid = 1'b1;
      @(posedge clk); #1;
      if (if8.y_q !== 8'h07 || par8 !== 1'b1) begin n_fail++; $display("FAIL par_07: got y_q=%h par=%b expected 07 1", if8.y_q, par8); end
      n_checks++;
      if8.in_valid = 1'b0; if8.a = 8'h03;
      @(posedge clk); #1;
      if (par8 !== 1'b1) begin n_fail++; $display("FAIL par_hold: got %b expected 1", par8); end
      n_checks++;
      if8.in_valid = 1'b1;
      @(posedge clk); #1;
      if (par8 !== 1'b0) begin n_fail++; $display("FAIL par_03: got %b expected 0", par8); end
      n_checks++;
      if8.in_valid = 1'b0;
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      if1.a = '0; if1.b = '0; if1.in_valid = 1'b0;
      if8.a = '0; if8.b = '0; if8.in_valid = 1'b0;
      if4.a = '0; if4.b = '0; if4.in_valid = 1'b0;
      ifs.a = '0; ifs.b = '0; ifs.in_valid = 1'b0;
      clr1 = 1'b0; clr8 = 1'b0; clr4 = 1'b0; clrs = 1'b0;
      #1;
      test_reset();
      #1;
      rst_n = 1'b1;
      test_truth_table();
      test_basic_capture();
      test_hold();
      test_saturate();
      test_back_to_back();
      test_midstream_reset();
`ifdef AND_GATE_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
